// File: rtl/sa_feed_ctrl.sv
// Systolic-array pass sequencer: K buffer reads with a staggered row-valid wavefront, drain, then a done pulse.
// rd_en_o follows en_i combinationally in FEED; en_i=0 freezes all pass state (stall as backpressure).
module sa_feed_ctrl #(
    parameter int ROWS = 4,
    parameter int COLS = 4,
    parameter int K_W  = 8
) (
    input  logic            clk_i,
    input  logic            rstn_i,
    input  logic            start_i,
    input  logic [K_W-1:0]  k_len_i,
    input  logic            en_i,
    output logic            rd_en_o,
    output logic [K_W-1:0]  rd_addr_o,
    output logic [ROWS-1:0] row_vld_o,
    output logic            busy_o,
    output logic            done_o
);

    localparam int DRAIN_LEN = ROWS + COLS - 1;
    localparam int DW        = $clog2(DRAIN_LEN + 1);
    localparam logic [DW-1:0] DRAIN_LAST = DW'(DRAIN_LEN - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FEED,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t          state_q;
    logic [K_W-1:0]  count_q;
    logic [K_W-1:0]  len_q;
    logic [DW-1:0]   drain_q;
    logic [ROWS-1:0] wave_q;
    logic            fire;

    assign fire = (state_q == S_FEED) && en_i;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q <= S_IDLE;
            count_q <= '0;
            len_q   <= '0;
            drain_q <= '0;
            wave_q  <= '0;
        end else begin
            // The wavefront keeps shifting through DRAIN until it empties.
            if (en_i) begin
                wave_q <= {wave_q[ROWS-2:0], fire};
            end
            case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        if (k_len_i != '0) begin
                            len_q   <= k_len_i;
                            count_q <= '0;
                            state_q <= S_FEED;
                        end else begin
                            state_q <= S_DONE;
                        end
                    end
                end
                S_FEED: begin
                    if (en_i) begin
                        count_q <= count_q + 1'b1;
                        if (count_q == len_q - 1'b1) begin
                            drain_q <= '0;
                            state_q <= S_DRAIN;
                        end
                    end
                end
                S_DRAIN: begin
                    if (en_i) begin
                        if (drain_q == DRAIN_LAST) begin
                            state_q <= S_DONE;
                        end else begin
                            drain_q <= drain_q + 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign rd_en_o   = fire;
    assign rd_addr_o = (state_q == S_FEED) ? count_q : '0;
    assign row_vld_o = wave_q;
    assign busy_o    = (state_q == S_FEED) || (state_q == S_DRAIN);
    assign done_o    = (state_q == S_DONE);

endmodule

// File: tb/tb_sa_feed_ctrl.sv
// Bench for sa_feed_ctrl: per-cycle expected outputs are queued by the driver and checked by a monitor.
module tb_sa_feed_ctrl;

    localparam int ROWS = 4;
    localparam int COLS = 4;
    localparam int K_W  = 8;
    localparam int DRAIN_LEN = ROWS + COLS - 1;

    typedef struct packed {
        logic            rd_en;
        logic [K_W-1:0]  addr;
        logic [ROWS-1:0] rv;
        logic            busy;
        logic            done;
    } obs_t;

    logic            clk_i;
    logic            rstn_i;
    logic            start_i;
    logic [K_W-1:0]  k_len_i;
    logic            en_i;
    logic            rd_en_o;
    logic [K_W-1:0]  rd_addr_o;
    logic [ROWS-1:0] row_vld_o;
    logic            busy_o;
    logic            done_o;

    obs_t exp_q[$];
    obs_t mon_exp;
    obs_t mon_act;
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;

    sa_feed_ctrl #(.ROWS(ROWS), .COLS(COLS), .K_W(K_W)) dut (
        .clk_i     (clk_i),
        .rstn_i    (rstn_i),
        .start_i   (start_i),
        .k_len_i   (k_len_i),
        .en_i      (en_i),
        .rd_en_o   (rd_en_o),
        .rd_addr_o (rd_addr_o),
        .row_vld_o (row_vld_o),
        .busy_o    (busy_o),
        .done_o    (done_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    always @(posedge clk_i) cyc <= cyc + 1;

    // Monitor: one expected record per cycle, sampled mid-cycle.
    always @(negedge clk_i) begin
        if (exp_q.size() > 0) begin
            mon_exp = exp_q.pop_front();
            mon_act = {rd_en_o, rd_addr_o, row_vld_o, busy_o, done_o};
            total++;
            if (mon_act !== mon_exp) begin
                bad++;
                $display("FAIL outputs cyc=%0d got rd_en=%b addr=%0d row_vld=%b busy=%b done=%b want rd_en=%b addr=%0d row_vld=%b busy=%b done=%b",
                         cyc, mon_act.rd_en, mon_act.addr, mon_act.rv, mon_act.busy, mon_act.done,
                         mon_exp.rd_en, mon_exp.addr, mon_exp.rv, mon_exp.busy, mon_exp.done);
            end
        end
    end

    // Reference: with E = enabled cycles seen so far in the pass, reads occupy
    // enabled slots 1..len, the drain the next DRAIN_LEN, then done; row r carries
    // the read issued r+1 enabled cycles earlier.
    task automatic run_pass(input int len, input int mode, input int strays, input int abort_at);
        int   e_cnt;
        int   lim;
        bit   en;
        obs_t x;
        @(posedge clk_i); #1;
        start_i = 1'b1;
        k_len_i = K_W'(len);
        en_i    = 1'($urandom_range(0, 1));
        exp_q.push_back('0);
        e_cnt = 0;
        lim   = 4 * (len + DRAIN_LEN + 1);
        for (int c = 1; c < 8 * lim + 100; c++) begin
            @(posedge clk_i); #1;
            start_i = 1'b0;
            k_len_i = K_W'($urandom);
            case (mode)
                0:       en = 1'b1;
                1:       en = (c != 2);
                default: en = (c > lim) ? 1'b1 : ($urandom_range(0, 3) != 0);
            endcase
            if (strays == 1 && (c == 3 || c == 11)) start_i = 1'b1;
            if (strays == 2 && $urandom_range(0, 3) == 0) start_i = 1'b1;
            en_i = en;
            if (c == abort_at) begin
                rstn_i = 1'b0;
                exp_q.push_back('0);
                @(posedge clk_i); #1;
                rstn_i  = 1'b1;
                start_i = 1'b0;
                exp_q.push_back('0);
                return;
            end
            x = '0;
            if (len == 0) begin
                x.done = 1'b1;
                exp_q.push_back(x);
                return;
            end
            if (e_cnt < len) begin
                x.busy  = 1'b1;
                x.rd_en = en;
                x.addr  = K_W'(e_cnt);
            end else if (e_cnt < len + DRAIN_LEN) begin
                x.busy = 1'b1;
            end else begin
                x.done = 1'b1;
            end
            for (int r = 0; r < ROWS; r++) begin
                x.rv[r] = (e_cnt - r >= 1) && (e_cnt - r <= len);
            end
            exp_q.push_back(x);
            if (x.done) return;
            e_cnt += int'(en);
        end
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk_i); #1;
            start_i = 1'b0;
            en_i    = 1'($urandom_range(0, 1));
            exp_q.push_back('0);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired cyc=%0d", cyc);
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1, "timeout");
    end

    initial begin
        rstn_i  = 1'b0;
        start_i = 1'b0;
        k_len_i = '0;
        en_i    = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk_i); #1;
            en_i = 1'($urandom_range(0, 1));
            exp_q.push_back('0);
        end
        rstn_i = 1'b1;
        idle_cycles(2);

        run_pass(3, 0, 0, 0);
        idle_cycles(1);
        run_pass(3, 1, 0, 0);
        idle_cycles(1);
        run_pass(0, 0, 0, 0);
        idle_cycles(2);
        run_pass(3, 0, 1, 0);
        idle_cycles(1);
        run_pass(3, 0, 0, 5);
        run_pass(2, 0, 0, 0);
        idle_cycles(1);
        run_pass(255, 0, 0, 0);
        idle_cycles(1);
        run_pass(255, 2, 2, 0);
        idle_cycles(1);

        for (int p = 0; p < 40; p++) begin
            run_pass($urandom_range(0, 20), 2, 2,
                     ($urandom_range(0, 7) == 0) ? $urandom_range(1, 12) : 0);
            idle_cycles($urandom_range(0, 2));
        end

        idle_cycles(2);
        @(posedge clk_i);
        @(posedge clk_i);
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain_queue left=%0d want 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
